dmem_port_arbiter: RTL and testbench
====================================

Name: dmem_port_arbiter

Overview:
- Shares the single-port data memory between the load unit and store-buffer retirement, one access per cycle.
- Generates the load-occupancy signal (memoccupy_ld) consumed by the store buffer, together with a store-retire grant.
- Loads have priority. A starvation counter and the store-buffer-full condition force store slots.
- A fence/drain sequencer empties the store buffer before acknowledging a memory fence.

Parameters:
STARVE_LIMIT, 4, consecutive cycles an eligible store may be denied before it is force-granted (1..2^CNT_W-1)
CNT_W, 3, width of the starvation counter
ADDR_LEN, 32, load address width (pass-through to memory address mux select only)

Ports:
clk  in  1  clock
reset  in  1  synchronous reset, active-low
ld_req  in  1  load unit requests memory read this cycle
ld_grant  out  1  load granted this cycle (combinational)
memoccupy_ld  out  1  equals ld_grant; to store buffer
ld_rdata_valid  out  1  read data valid; ld_grant delayed one cycle
st_pend  in  1  store-buffer head is valid and completed
sb_full  in  1  store buffer full
sb_empty  in  1  store buffer has no valid entries
prmiss  in  1  branch mispredict this cycle
st_grant  out  1  store head retires this cycle (combinational; dmem write enable)
fence_req  in  1  fence wants store buffer drained; held until fence_ack
fence_ack  out  1  one-cycle pulse, drain complete
dmem_sel  out  1  memory address/data mux: 1 = store buffer, 0 = load
starve_cnt  out  CNT_W  current starvation count (debug/verification)

Behaviour:
- Interface: reset reset, synchronous, active-low; clock clk. reset==0 at posedge gives: state=NORMAL, starve_cnt=0, ld_rdata_valid=0, fence_ack=0. Combinational outputs follow from that state. Reset mid-drain aborts the drain with no ack.
- st_elig = st_pend & ~prmiss. No store is ever granted in a prmiss cycle.
- force_st = sb_full | (starve_cnt >= STARVE_LIMIT).
- States: NORMAL, DRAIN, ACK.
- NORMAL:
  - ld_grant = ld_req & ~(st_elig & force_st).
  - st_grant = st_elig & ~ld_grant.
  - fence_req=1 -> DRAIN on next cycle. The grant in that cycle still follows NORMAL rules.
- DRAIN:
  - ld_grant = 0. st_grant = st_elig.
  - sb_empty & ~st_pend -> ACK.
  - prmiss=1 -> NORMAL, no ack (fence squashed). prmiss has priority over the empty check.
- ACK:
  - fence_ack=1, ld_grant = 0, st_grant = st_elig.
  - Always -> NORMAL next cycle. fence_req is ignored in ACK.
  - fence_req still high in NORMAL starts a new drain.
- dmem_sel = st_grant. memoccupy_ld = ld_grant. ld_grant and st_grant are never both 1.
- starve_cnt, next value:
  - 0 if st_grant or ~st_pend.
  - Otherwise starve_cnt+1 when st_pend & ~st_grant, saturating at STARVE_LIMIT.
  - prmiss cycles with st_pend count as denials.
- ld_rdata_valid(t+1) = ld_grant(t). It is not gated by prmiss; the load unit discards squashed results.
- Worst case, an eligible store waits STARVE_LIMIT cycles under continuous loads, plus any prmiss cycles.

Test Plan:
- Reset: hold reset=0 two cycles with all inputs 1 -> ld_rdata_valid=0, fence_ack=0, starve_cnt=0. Release with ld_req=1, st_pend=0 -> ld_grant=1, and ld_rdata_valid=1 the following cycle.
- Starvation, STARVE_LIMIT=4: ld_req=1 and st_pend=1 continuously.
  - Cycles 0-3: ld_grant=1, starve_cnt 0,1,2,3.
  - Cycle 4: cnt=4, so st_grant=1, ld_grant=0, dmem_sel=1.
  - Cycle 5: cnt=0, ld_grant=1.
- sb_full=1, st_pend=1, ld_req=1, cnt=0 -> st_grant=1 immediately. Same cycle with prmiss=1 -> st_grant=0, ld_grant=1, cnt increments.
- Fence: fence_req=1 with 3 pending stores, ld_req=1.
  - DRAIN grants 3 stores on consecutive cycles with ld_grant=0 throughout.
  - Then sb_empty=1, st_pend=0 -> ACK, fence_ack pulses exactly 1 cycle.
  - Next cycle NORMAL, ld_grant=1.
- Drain abort: in DRAIN with 2 stores pending, assert prmiss -> no st_grant that cycle, return to NORMAL, fence_ack never asserts. Repeat with reset=0 mid-DRAIN -> same outcome.
- Random: ld_req/st_pend/prmiss/sb_full at 50% for 10k cycles -> never ld_grant&st_grant, never st_grant&prmiss, no store denied more than STARVE_LIMIT non-prmiss cycles.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// Single-port dmem arbiter: loads first, stores forced by starvation/full, fence drain sequencer.
// Grants are combinational (zero latency); read-valid lags ld_grant by one cycle; no backpressure beyond grant denial.
module dmem_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3,
    parameter int ADDR_LEN     = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ld_req,
    output logic             ld_grant,
    output logic             memoccupy_ld,
    output logic             ld_rdata_valid,
    input  logic             st_pend,
    input  logic             sb_full,
    input  logic             sb_empty,
    input  logic             prmiss,
    output logic             st_grant,
    input  logic             fence_req,
    output logic             fence_ack,
    output logic             dmem_sel,
    output logic [CNT_W-1:0] starve_cnt
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > (2**CNT_W) - 1 || ADDR_LEN < 1) begin : g_bad_param
        $error("dmem_port_arbiter: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        DRAIN  = 2'd1,
        ACK    = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rvld_q;
    logic             st_elig;
    logic             force_st;

    assign st_elig  = st_pend & ~prmiss;
    assign force_st = sb_full | (cnt_q >= LIMIT);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= NORMAL;
            cnt_q   <= '0;
            rvld_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rvld_q  <= ld_grant;
        end
    end

    always_comb begin
        state_d   = state_q;
        ld_grant  = 1'b0;
        st_grant  = 1'b0;
        fence_ack = 1'b0;
        unique case (state_q)
            NORMAL: begin
                ld_grant = ld_req & ~(st_elig & force_st);
                st_grant = st_elig & ~ld_grant;
                if (fence_req) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                st_grant = st_elig;
                // A mispredict squashes the fence even if the buffer just emptied.
                if (prmiss) begin
                    state_d = NORMAL;
                end else if (sb_empty && !st_pend) begin
                    state_d = ACK;
                end
            end
            ACK: begin
                fence_ack = 1'b1;
                st_grant  = st_elig;
                state_d   = NORMAL;
            end
            default: begin
                state_d = NORMAL;
            end
        endcase
    end

    // Mispredict cycles with a pending store count as denials, so the bound still holds.
    always_comb begin
        cnt_d = cnt_q;
        if (st_grant || !st_pend) begin
            cnt_d = '0;
        end else if (cnt_q < LIMIT) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign memoccupy_ld   = ld_grant;
    assign dmem_sel       = st_grant;
    assign ld_rdata_valid = rvld_q;
    assign starve_cnt     = cnt_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed checks of reset, starvation, sb_full, fence drain/abort, plus randomised invariants.
module tb_dmem_port_arbiter;

    localparam int LIM = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       ld_req, st_pend, sb_full, sb_empty, prmiss, fence_req;
    logic       ld_grant, memoccupy_ld, ld_rdata_valid, st_grant, fence_ack, dmem_sel;
    logic [2:0] starve_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dmem_port_arbiter #(.STARVE_LIMIT(LIM), .CNT_W(3), .ADDR_LEN(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .ld_req         (ld_req),
        .ld_grant       (ld_grant),
        .memoccupy_ld   (memoccupy_ld),
        .ld_rdata_valid (ld_rdata_valid),
        .st_pend        (st_pend),
        .sb_full        (sb_full),
        .sb_empty       (sb_empty),
        .prmiss         (prmiss),
        .st_grant       (st_grant),
        .fence_req      (fence_req),
        .fence_ack      (fence_ack),
        .dmem_sel       (dmem_sel),
        .starve_cnt     (starve_cnt)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs are then driven and outputs sampled 1-2ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic lr, input logic sp, input logic sf,
                         input logic se, input logic pm, input logic fr);
        ld_req = lr; st_pend = sp; sb_full = sf; sb_empty = se; prmiss = pm; fence_req = fr;
        #1;
    endtask

    int wait_np;

    initial begin
        reset = 1'b0;
        drive(1, 1, 1, 1, 1, 1);
        step();
        step();
        chk("rst_rvld", ld_rdata_valid, 0);
        chk("rst_ack", fence_ack, 0);
        chk("rst_cnt", starve_cnt, 0);

        reset = 1'b1;
        drive(1, 0, 0, 1, 0, 0);
        chk("rel_ldg", ld_grant, 1);
        chk("rel_occ", memoccupy_ld, 1);
        step();
        chk("rel_rvld", ld_rdata_valid, 1);

        // Starvation under continuous loads
        drive(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < LIM; i++) begin
            chk("stv_ldg", ld_grant, 1);
            chk("stv_stg", st_grant, 0);
            chk("stv_cnt", starve_cnt, i);
            step();
        end
        chk("stv4_cnt", starve_cnt, 4);
        chk("stv4_stg", st_grant, 1);
        chk("stv4_ldg", ld_grant, 0);
        chk("stv4_sel", dmem_sel, 1);
        step();
        chk("stv5_cnt", starve_cnt, 0);
        chk("stv5_ldg", ld_grant, 1);
        chk("stv5_rvld", ld_rdata_valid, 0);

        // sb_full forces a store immediately; prmiss blocks it
        drive(1, 1, 1, 0, 0, 0);
        chk("full_stg", st_grant, 1);
        chk("full_ldg", ld_grant, 0);
        drive(1, 1, 1, 0, 1, 0);
        chk("fpm_stg", st_grant, 0);
        chk("fpm_ldg", ld_grant, 1);
        step();
        chk("fpm_cnt", starve_cnt, 1);
        drive(0, 0, 0, 1, 0, 0);
        step();
        chk("clr_cnt", starve_cnt, 0);

        // Fence with three pending stores
        drive(1, 1, 0, 0, 0, 1);
        chk("fn_ldg", ld_grant, 1);
        chk("fn_stg", st_grant, 0);
        step();
        for (int i = 0; i < 3; i++) begin
            chk("dr_ldg", ld_grant, 0);
            chk("dr_stg", st_grant, 1);
            chk("dr_ack", fence_ack, 0);
            step();
        end
        drive(1, 0, 0, 1, 0, 1);
        chk("dr_empty_stg", st_grant, 0);
        chk("dr_empty_ldg", ld_grant, 0);
        chk("dr_empty_ack", fence_ack, 0);
        step();
        chk("ack_pulse", fence_ack, 1);
        chk("ack_ldg", ld_grant, 0);
        drive(1, 0, 0, 1, 0, 0);
        step();
        chk("post_ack", fence_ack, 0);
        chk("post_ldg", ld_grant, 1);

        // Drain aborted by mispredict
        drive(1, 1, 0, 0, 0, 1);
        step();
        chk("ab_ldg", ld_grant, 0);
        chk("ab_stg", st_grant, 1);
        step();
        drive(1, 1, 0, 0, 1, 0);
        chk("ab_pm_stg", st_grant, 0);
        chk("ab_pm_ldg", ld_grant, 0);
        step();
        drive(1, 1, 0, 0, 0, 0);
        chk("ab_norm_ldg", ld_grant, 1);
        for (int i = 0; i < 3; i++) begin
            chk("ab_noack", fence_ack, 0);
            step();
        end

        // Drain aborted by reset
        drive(0, 0, 0, 1, 0, 0);
        step();
        drive(1, 1, 0, 0, 0, 1);
        step();
        chk("rd_ldg", ld_grant, 0);
        reset = 1'b0;
        drive(1, 1, 0, 0, 0, 0);
        step();
        reset = 1'b1;
        #1;
        chk("rd_ldg_norm", ld_grant, 1);
        chk("rd_cnt", starve_cnt, 0);
        for (int i = 0; i < 3; i++) begin
            chk("rd_noack", fence_ack, 0);
            step();
        end

        // Random invariants
        drive(0, 0, 0, 1, 0, 0);
        step();
        wait_np = 0;
        for (int i = 0; i < 10000; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'b0);
            if (ld_grant && st_grant) chk("rnd_both", 1, 0);
            if (st_grant && prmiss)   chk("rnd_pm_st", 1, 0);
            if (st_grant || !st_pend) wait_np = 0;
            else if (!prmiss)         wait_np++;
            if (wait_np > LIM) chk("rnd_starve", wait_np, LIM);
            if (i % 1000 == 0) chk("rnd_sel", dmem_sel, st_grant);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
